// File: rtl/shift_cmd_deserializer.sv
// shift_cmd_deserializer: serial command receiver for a shift stage.
// A frame is a start bit (1), then 11 payload bits MSB first (md, p2[1:0],
// number[7:0]), then an even-parity bit when PARITY_CHECK_EN is defined.
// A checked command is held with cmd_valid=1 until cmd_ready accepts it.
// Handshake: the command transfers on any clk edge where cmd_valid and
// cmd_ready are both 1; cmd_valid then drops on the next cycle. cmd_ready is
// ignored while cmd_valid=0.
// Build option: define PARITY_CHECK_EN to add the parity bit and PAR state.
module shift_cmd_deserializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdi,
  input  logic       sdi_en,
  input  logic       cmd_ready,
  output logic [7:0] number,
  output logic [1:0] p2,
  output logic       md,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
`ifdef PARITY_CHECK_EN
    PAR  = 2'd2,
`endif
    HOLD = 2'd3
  } state_t;

  // With parity the whole payload sits in the shift register while the
  // parity bit arrives; without it the last payload bit is taken straight
  // from sdi, so one fewer stage is needed.
`ifdef PARITY_CHECK_EN
  localparam int SR_W = 11;
`else
  localparam int SR_W = 10;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [SR_W-1:0]   sr;
  logic [10:0]       payload_in;
  logic              last_bit;
  logic              load_cmd;

  assign last_bit = (cnt == 4'd10);

`ifdef PARITY_CHECK_EN
  assign payload_in = sr;
`else
  assign payload_in = {sr, sdi};
`endif

  // Command registers load only on the transition into HOLD.
  assign load_cmd = (state != HOLD) && (state_nxt == HOLD);

  assign cmd_valid = (state == HOLD);
`ifdef PARITY_CHECK_EN
  assign busy = (state == RECV) || (state == PAR);
`else
  assign busy = (state == RECV);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; every transition except the HOLD exit needs a sampled bit.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (sdi_en && sdi) state_nxt = RECV;
      RECV: begin
        if (sdi_en && last_bit) begin
`ifdef PARITY_CHECK_EN
          state_nxt = PAR;
`else
          state_nxt = HOLD;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      PAR:  if (sdi_en) state_nxt = (sdi == ^sr) ? HOLD : IDLE;
`endif
      HOLD: if (cmd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter, shift register and command output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 4'd0;
      sr     <= '0;
      number <= 8'h00;
      p2     <= 2'b00;
      md     <= 1'b0;
    end else begin
      if (state == IDLE && sdi_en && sdi) begin
        cnt <= 4'd0;
      end else if (state == RECV && sdi_en) begin
        cnt <= last_bit ? 4'd0 : cnt + 4'd1;
        if (!(SR_W == 10 && last_bit)) sr <= {sr[SR_W-2:0], sdi};
      end
      if (load_cmd) {md, p2, number} <= payload_in;
    end
  end

  // Overrun: a bit offered while a command is held is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= (state == HOLD) && sdi_en;
  end

`ifdef PARITY_CHECK_EN
  // Frame error: parity bit disagrees with even parity over the payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= (state == PAR) && sdi_en && (sdi != ^sr);
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule
